// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared definitions for the ALU arbiter: ALU function codes,
//             flag bit positions, bus widths and arbiter state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Bus widths of the attached ALU
  localparam int ALU_DATA_W = 32;
  localparam int FUNSEL_W   = 5;
  localparam int FLAGS_W    = 4;

  // ALU FunSel codes used by the requesters
  localparam logic [FUNSEL_W-1:0] FS_ADD32 = 5'b10100;
  localparam logic [FUNSEL_W-1:0] FS_SUB32 = 5'b10110;
  localparam logic [FUNSEL_W-1:0] FS_XOR32 = 5'b11001;

  // Flag bit positions inside alu_flags / rsp_flags (Z|C|N|V)
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // Arbiter sequencing: accept one op, wait for the ALU, hand back result
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter_if
//  Purpose  : Bundles the two request channels, the ALU drive/return signals
//             and the shared response channel of the ALU arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if;
  import alu_pkg::*;

  // Requester 0
  logic                  req0_valid;
  logic                  req0_ready;
  logic [FUNSEL_W-1:0]   req0_funsel;
  logic [ALU_DATA_W-1:0] req0_a;
  logic [ALU_DATA_W-1:0] req0_b;
  logic                  req0_cin;

  // Requester 1
  logic                  req1_valid;
  logic                  req1_ready;
  logic [FUNSEL_W-1:0]   req1_funsel;
  logic [ALU_DATA_W-1:0] req1_a;
  logic [ALU_DATA_W-1:0] req1_b;
  logic                  req1_cin;

  // ALU side
  logic [FUNSEL_W-1:0]   alu_funsel;
  logic [ALU_DATA_W-1:0] alu_a;
  logic [ALU_DATA_W-1:0] alu_b;
  logic                  alu_cin;
  logic [ALU_DATA_W-1:0] alu_out;
  logic [FLAGS_W-1:0]    alu_flags;

  // Shared response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [ALU_DATA_W-1:0] rsp_result;
  logic [FLAGS_W-1:0]    rsp_flags;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_funsel, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_funsel, req1_a, req1_b, req1_cin,
    output req1_ready,
    output alu_funsel, alu_a, alu_b, alu_cin,
    input  alu_out, alu_flags,
    output rsp_valid, rsp_id, rsp_result, rsp_flags,
    input  rsp_ready
  );

  // Requester / ALU / consumer side
  modport master (
    output req0_valid, req0_funsel, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_funsel, req1_a, req1_b, req1_cin,
    input  req1_ready,
    input  alu_funsel, alu_a, alu_b, alu_cin,
    output alu_out, alu_flags,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags,
    output rsp_ready
  );

endinterface : alu_arbiter_if
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin grant. A lone requester always wins; when
//             both request, the one that was not granted last time wins.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // Pick the winner purely from current requests and the previous grant
  always_comb begin
    grant_valid = valid0 | valid1;
    grant_id    = 1'b0;
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end else if (valid1) begin
      grant_id = 1'b1;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Shares one registered ALU between two requesters. Grants one
//             op at a time round-robin, holds the ALU inputs while the ALU
//             result and flags settle, then returns them tagged with the
//             requester id on a valid/ready response channel.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int SETTLE = 3,           // edges until alu_flags valid, 1..15
  parameter int DATA_W = ALU_DATA_W   // fixed by the attached ALU
) (
  input  logic          clock,
  input  logic          reset,        // synchronous, active low
  alu_arbiter_if.slave  bus
);

  // Counter value seen during the last ISSUE cycle; capture happens there
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE);

  arb_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;

  logic [FUNSEL_W-1:0] alu_funsel_q, alu_funsel_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic                alu_cin_q, alu_cin_d;

  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic [FLAGS_W-1:0]  rsp_flags_q, rsp_flags_d;

  logic                grant_valid;
  logic                grant_id;
  logic                accept;

  rr_arb2 u_rr_arb2 (
    .valid0      (bus.req0_valid),
    .valid1      (bus.req1_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Ready is only offered while idle, and only to the current winner
  assign accept         = (state_q == ST_IDLE) && grant_valid;
  assign bus.req0_ready = accept && !grant_id;
  assign bus.req1_ready = accept &&  grant_id;

  assign bus.alu_funsel = alu_funsel_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_cin    = alu_cin_q;

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;

  // Next-state logic: accept, wait SETTLE+1 cycles, capture, hand back
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    alu_funsel_d = alu_funsel_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cin_d    = alu_cin_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          if (grant_id) begin
            alu_funsel_d = bus.req1_funsel;
            alu_a_d      = bus.req1_a;
            alu_b_d      = bus.req1_b;
            alu_cin_d    = bus.req1_cin;
          end else begin
            alu_funsel_d = bus.req0_funsel;
            alu_a_d      = bus.req0_a;
            alu_b_d      = bus.req0_b;
            alu_cin_d    = bus.req0_cin;
          end
          rsp_id_d     = grant_id;
          last_grant_d = grant_id;
          cnt_d        = 4'd0;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // The counter stops at SETTLE_LAST, so it never wraps
        if (cnt_q == SETTLE_LAST) begin
          rsp_result_d = bus.alu_out;
          rsp_flags_d  = bus.alu_flags;
          rsp_valid_d  = 1'b1;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_DONE: begin
        // Response stays frozen until the consumer takes it
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight op without a response
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      alu_funsel_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      alu_funsel_q <= alu_funsel_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter. Three arbiters with
//             SETTLE = 3, 1, 5 share the same stimulus; each drives its own
//             registered ALU model whose flags lag by SETTLE edges.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset;
  logic [1:0]       rv;
  logic [1:0][4:0]  rfs;
  logic [1:0][31:0] ra;
  logic [1:0][31:0] rb;
  logic [1:0]       rc;
  logic             rsp_ready;

  logic [2:0]       rdy0, rdy1, rspv, rid, ac;
  logic [2:0][31:0] rres, aa, ab;
  logic [2:0][3:0]  rflg;
  logic [2:0][4:0]  afs;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit m_last;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference ALU behaviour: returns {Z,C,N,V, result}
  function automatic logic [35:0] alu_calc(logic [4:0] fs, logic [31:0] a, logic [31:0] b, logic cin);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (fs)
      FS_ADD32: begin
        s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      FS_SUB32: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      FS_XOR32: r = a ^ b;
      default:  r = a;
    endcase
    return {(r == 32'd0), c, r[31], v, r};
  endfunction

  // Round-robin rule: a lone requester wins, otherwise the one not served last
  function automatic int rr_pick(bit p0, bit p1, bit last);
    if (p0 && p1) return last ? 0 : 1;
    return p1 ? 1 : 0;
  endfunction

  function automatic logic [4:0] rand_fs();
    case ($urandom_range(0, 2))
      0:       return FS_ADD32;
      1:       return FS_SUB32;
      default: return FS_XOR32;
    endcase
  endfunction

  // Lane g: one arbiter plus its ALU model
  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int ST = (g == 0) ? 3 : ((g == 1) ? 1 : 5);
    alu_arbiter_if bus ();
    logic [31:0] out_q;
    logic [3:0]  flg_pipe [ST];

    assign bus.req0_valid  = rv[0];
    assign bus.req0_funsel = rfs[0];
    assign bus.req0_a      = ra[0];
    assign bus.req0_b      = rb[0];
    assign bus.req0_cin    = rc[0];
    assign bus.req1_valid  = rv[1];
    assign bus.req1_funsel = rfs[1];
    assign bus.req1_a      = ra[1];
    assign bus.req1_b      = rb[1];
    assign bus.req1_cin    = rc[1];
    assign bus.rsp_ready   = rsp_ready;
    assign bus.alu_out     = out_q;
    assign bus.alu_flags   = flg_pipe[ST-1];

    always @(posedge clock) begin : p_alu
      logic [35:0] t;
      t = alu_calc(bus.alu_funsel, bus.alu_a, bus.alu_b, bus.alu_cin);
      out_q       <= t[31:0];
      flg_pipe[0] <= t[35:32];
      for (int k = 1; k < ST; k++) flg_pipe[k] <= flg_pipe[k-1];
    end

    alu_arbiter #(.SETTLE(ST), .DATA_W(32)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
    );

    assign rdy0[g] = bus.req0_ready;
    assign rdy1[g] = bus.req1_ready;
    assign rspv[g] = bus.rsp_valid;
    assign rid[g]  = bus.rsp_id;
    assign rres[g] = bus.rsp_result;
    assign rflg[g] = bus.rsp_flags;
    assign afs[g]  = bus.alu_funsel;
    assign aa[g]   = bus.alu_a;
    assign ab[g]   = bus.alu_b;
    assign ac[g]   = bus.alu_cin;
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    repeat (n) tick();
    reset  = 1'b1;
    m_last = 1'b1;
  endtask

  task automatic drive_req(input int id, input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b, input logic cin);
    rfs[id] = fs; ra[id] = a; rb[id] = b; rc[id] = cin; rv[id] = 1'b1;
  endtask

  // Waits for ready on lane 0, returns one cycle after the handshake edge
  task automatic wait_ready(input int id, output int acc, output bit ok);
    ok = 1'b0; acc = -1;
    for (int t = 0; t < 40; t++) begin
      #1;
      if ((id == 0) ? rdy0[0] : rdy1[0]) begin
        ok = 1'b1; acc = cyc;
        tick();
        break;
      end
      tick();
    end
  endtask

  // Waits for a lane-0 response, holds rsp_ready low for 'hold' extra cycles
  task automatic wait_rsp(input int hold, output int rcyc, output logic id, output logic [31:0] res,
                          output logic [3:0] flg, output bit ok);
    ok = 1'b0; rcyc = -1; id = 1'b0; res = '0; flg = '0;
    rsp_ready = (hold == 0);
    for (int t = 0; t < 60; t++) begin
      #1;
      if (rspv[0]) begin
        ok = 1'b1; rcyc = cyc; id = rid[0]; res = rres[0]; flg = rflg[0];
        break;
      end
      tick();
    end
    if (ok) begin
      repeat (hold) tick();
      rsp_ready = 1'b1;
      tick();
    end
    rsp_ready = 1'b1;
  endtask

  task automatic run_op(input int id, input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input int hold, output int acc, output int rcyc,
                        output logic [4:0] fs_c1, output logic rid_o, output logic [31:0] res,
                        output logic [3:0] flg, output bit ok);
    bit ok1;
    drive_req(id, fs, a, b, cin);
    wait_ready(id, acc, ok1);
    fs_c1 = afs[0];
    rv[id] = 1'b0;
    rcyc = -1; rid_o = 1'b0; res = '0; flg = '0; ok = 1'b0;
    if (ok1) begin
      wait_rsp(hold, rcyc, rid_o, res, flg, ok);
      m_last = id[0];
    end
  endtask

  task automatic test_reset();
    rv = 2'b00; rsp_ready = 1'b0;
    apply_reset(2);
    #1;
    n_checks++; if (rspv[0] !== 1'b0)  $display("FAIL reset_rsp_valid: got %0h want 0", rspv[0]); else n_pass++;
    n_checks++; if (rid[0] !== 1'b0)   $display("FAIL reset_rsp_id: got %0h want 0", rid[0]); else n_pass++;
    n_checks++; if (rres[0] !== 32'd0) $display("FAIL reset_rsp_result: got %0h want 0", rres[0]); else n_pass++;
    n_checks++; if (rflg[0] !== 4'd0)  $display("FAIL reset_rsp_flags: got %0h want 0", rflg[0]); else n_pass++;
    n_checks++; if (afs[0] !== 5'd0)   $display("FAIL reset_alu_funsel: got %0h want 0", afs[0]); else n_pass++;
    n_checks++; if (aa[0] !== 32'd0)   $display("FAIL reset_alu_a: got %0h want 0", aa[0]); else n_pass++;
    n_checks++; if (ab[0] !== 32'd0)   $display("FAIL reset_alu_b: got %0h want 0", ab[0]); else n_pass++;
    n_checks++; if (ac[0] !== 1'b0)    $display("FAIL reset_alu_cin: got %0h want 0", ac[0]); else n_pass++;
    n_checks++; if ({rdy0[0], rdy1[0]} !== 2'b00) $display("FAIL reset_ready: got %0b want 00", {rdy0[0], rdy1[0]}); else n_pass++;
    tick();
  endtask

  task automatic test_single_add();
    int acc, rcyc; logic [4:0] f1; logic id; logic [31:0] res; logic [3:0] flg; bit ok;
    rsp_ready = 1'b1;
    run_op(0, FS_ADD32, 32'd5, 32'd7, 1'b0, 0, acc, rcyc, f1, id, res, flg, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL add_timeout: got %0d want 1", ok); else n_pass++;
    n_checks++; if (rcyc - acc !== 5) $display("FAIL add_latency: got %0d want 5", rcyc - acc); else n_pass++;
    n_checks++; if (f1 !== 5'b10100) $display("FAIL add_alu_funsel_c1: got %0b want 10100", f1); else n_pass++;
    n_checks++; if (id !== 1'b0) $display("FAIL add_rsp_id: got %0d want 0", id); else n_pass++;
    n_checks++; if (res !== 32'd12) $display("FAIL add_result: got %0h want c", res); else n_pass++;
    n_checks++; if (flg !== 4'b0000) $display("FAIL add_flags: got %0b want 0000", flg); else n_pass++;
  endtask

  task automatic test_both_valid();
    int acc, rcyc, w; logic id; logic [31:0] res; logic [3:0] flg; bit ok; logic [35:0] e;
    apply_reset(1);
    drive_req(0, FS_XOR32, 32'h10, 32'h10, 1'b0);
    drive_req(1, FS_ADD32, 32'd1, 32'd1, 1'b0);
    w = rr_pick(1'b1, 1'b1, m_last);
    #1;
    n_checks++; if ({rdy1[0], rdy0[0]} !== ((w == 0) ? 2'b01 : 2'b10)) $display("FAIL both_first_grant: got %0b want winner %0d", {rdy1[0], rdy0[0]}, w); else n_pass++;
    tick(); rv[0] = 1'b0; m_last = 1'b0;
    wait_rsp(0, rcyc, id, res, flg, ok);
    e = alu_calc(FS_XOR32, 32'h10, 32'h10, 1'b0);
    n_checks++; if (id !== 1'b0) $display("FAIL both_rsp0_id: got %0d want 0", id); else n_pass++;
    n_checks++; if ({flg, res} !== e) $display("FAIL both_rsp0_value: got %0h want %0h", {flg, res}, e); else n_pass++;
    n_checks++; if (flg[FLAG_Z] !== 1'b1) $display("FAIL both_rsp0_zflag: got %0b want 1", flg[FLAG_Z]); else n_pass++;
    #1;
    n_checks++; if (rdy1[0] !== 1'b1 || cyc !== rcyc + 1) $display("FAIL both_req1_grant: got rdy %0b cyc %0d want 1 at %0d", rdy1[0], cyc, rcyc + 1); else n_pass++;
    tick(); rv[1] = 1'b0; m_last = 1'b1;
    wait_rsp(0, rcyc, id, res, flg, ok);
    n_checks++; if (id !== 1'b1 || res !== 32'd2 || ok !== 1'b1) $display("FAIL both_rsp1: got id %0d res %0h want id 1 res 2", id, res); else n_pass++;
    drive_req(0, FS_XOR32, $urandom(), $urandom(), 1'b0);
    drive_req(1, FS_ADD32, $urandom(), $urandom(), 1'b0);
    w = rr_pick(1'b1, 1'b1, m_last);
    #1;
    n_checks++; if ({rdy1[0], rdy0[0]} !== ((w == 0) ? 2'b01 : 2'b10)) $display("FAIL both_second_grant: got %0b want winner %0d", {rdy1[0], rdy0[0]}, w); else n_pass++;
    tick(); rv = 2'b00; m_last = w[0];
    wait_rsp(0, rcyc, id, res, flg, ok);
    n_checks++; if (id !== w[0]) $display("FAIL both_rsp2_id: got %0d want %0d", id, w); else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc, seen; bit ok; logic [35:0] e;
    e = alu_calc(FS_SUB32, 32'd5, 32'd7, 1'b0);
    rsp_ready = 1'b0;
    drive_req(1, FS_SUB32, 32'd5, 32'd7, 1'b0);
    wait_ready(1, acc, ok);
    rv[1] = 1'b0; m_last = 1'b1;
    n_checks++; if (ok !== 1'b1) $display("FAIL bp_accept_timeout: got %0d want 1", ok); else n_pass++;
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (rspv[0]) begin seen = 1; break; end
      tick();
    end
    n_checks++; if (seen !== 1) $display("FAIL bp_rsp_timeout: got %0d want 1", seen); else n_pass++;
    tick();
    rfs[0] = FS_ADD32; ra[0] = $urandom(); rb[0] = $urandom(); rc[0] = 1'b0;
    rfs[1] = FS_ADD32; ra[1] = $urandom(); rb[1] = $urandom(); rc[1] = 1'b0;
    rv = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++; if (rspv[0] !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %0b want 1", i, rspv[0]); else n_pass++;
      n_checks++; if (rres[0] !== 32'hFFFF_FFFE) $display("FAIL bp_hold_result[%0d]: got %0h want fffffffe", i, rres[0]); else n_pass++;
      n_checks++; if (rflg[0] !== e[35:32] || rflg[0][FLAG_N] !== 1'b1) $display("FAIL bp_hold_flags[%0d]: got %0b want %0b", i, rflg[0], e[35:32]); else n_pass++;
      n_checks++; if (rid[0] !== 1'b1) $display("FAIL bp_hold_id[%0d]: got %0d want 1", i, rid[0]); else n_pass++;
      n_checks++; if ({rdy0[0], rdy1[0]} !== 2'b00) $display("FAIL bp_hold_ready[%0d]: got %0b want 00", i, {rdy0[0], rdy1[0]}); else n_pass++;
      tick();
    end
    rv = 2'b00; rsp_ready = 1'b1;
    #1;
    n_checks++; if (rspv[0] !== 1'b1) $display("FAIL bp_release_valid: got %0b want 1", rspv[0]); else n_pass++;
    tick(); #1;
    n_checks++; if (rspv[0] !== 1'b0) $display("FAIL bp_after_transfer: got %0b want 0", rspv[0]); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_issue();
    int acc, rcyc, seen; logic [4:0] f1; logic id; logic [31:0] res, a, b; logic [3:0] flg; bit ok;
    logic [35:0] e;
    drive_req(1, FS_ADD32, $urandom(), $urandom(), 1'b1);
    wait_ready(1, acc, ok);
    rv[1] = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; m_last = 1'b1;
    #1;
    n_checks++; if (rspv[0] !== 1'b0) $display("FAIL rmid_rsp_valid: got %0b want 0", rspv[0]); else n_pass++;
    n_checks++; if ({afs[0], aa[0], ab[0], ac[0]} !== 70'd0) $display("FAIL rmid_alu_clear: got %0h/%0h/%0h/%0h want 0", afs[0], aa[0], ab[0], ac[0]); else n_pass++;
    seen = 0;
    for (int t = 0; t < 12; t++) begin
      tick(); #1;
      if (rspv[0]) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL rmid_no_response: got %0d cycles valid want 0", seen); else n_pass++;
    tick();
    a = $urandom(); b = $urandom();
    e = alu_calc(FS_SUB32, a, b, 1'b0);
    run_op(1, FS_SUB32, a, b, 1'b0, 0, acc, rcyc, f1, id, res, flg, ok);
    n_checks++; if (ok !== 1'b1 || id !== 1'b1 || {flg, res} !== e) $display("FAIL rmid_next_op: got ok %0d id %0d val %0h want 1 1 %0h", ok, id, {flg, res}, e); else n_pass++;
  endtask

  task automatic test_settle_sweep();
    int acc; int first [3]; logic [31:0] res [3];
    rsp_ready = 1'b1;
    apply_reset(1);
    drive_req(0, FS_ADD32, 32'd3, 32'd4, 1'b0);
    #1;
    acc = cyc;
    n_checks++; if (rdy0 !== 3'b111) $display("FAIL sweep_accept: got %0b want 111", rdy0); else n_pass++;
    tick(); rv[0] = 1'b0; m_last = 1'b0;
    for (int g = 0; g < 3; g++) begin first[g] = -1; res[g] = '0; end
    for (int t = 0; t < 20; t++) begin
      #1;
      for (int g = 0; g < 3; g++) if (first[g] < 0 && rspv[g]) begin first[g] = cyc; res[g] = rres[g]; end
      tick();
    end
    n_checks++; if (first[1] - acc !== 3) $display("FAIL sweep_settle1_cycle: got %0d want 3", first[1] - acc); else n_pass++;
    n_checks++; if (first[0] - acc !== 5) $display("FAIL sweep_settle3_cycle: got %0d want 5", first[0] - acc); else n_pass++;
    n_checks++; if (first[2] - acc !== 7) $display("FAIL sweep_settle5_cycle: got %0d want 7", first[2] - acc); else n_pass++;
    for (int g = 0; g < 3; g++) begin
      n_checks++; if (res[g] !== 32'd7) $display("FAIL sweep_result[%0d]: got %0h want 7", g, res[g]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int acc, rcyc, prev; logic [4:0] f1, fs; logic id; logic [31:0] res, a, b; logic [3:0] flg; bit ok, cin;
    logic [35:0] e;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      fs = rand_fs(); a = $urandom(); b = $urandom(); cin = 1'($urandom_range(0, 1));
      e = alu_calc(fs, a, b, cin);
      run_op(0, fs, a, b, cin, 0, acc, rcyc, f1, id, res, flg, ok);
      n_checks++; if (ok !== 1'b1 || id !== 1'b0 || {flg, res} !== e) $display("FAIL b2b_op[%0d]: got ok %0d id %0d val %0h want 1 0 %0h", i, ok, id, {flg, res}, e); else n_pass++;
      if (i > 0) begin
        n_checks++; if (acc !== prev + 1) $display("FAIL b2b_accept[%0d]: got cycle %0d want %0d", i, acc, prev + 1); else n_pass++;
      end
      prev = rcyc;
    end
  endtask

  task automatic test_random();
    bit [1:0] pend; int w, rcyc, hold; logic id; logic [31:0] res; logic [3:0] flg; bit ok;
    logic [35:0] e;
    pend = 2'b00;
    for (int r = 0; r < 24; r++) begin
      if (pend == 2'b00) begin
        pend = 2'($urandom_range(1, 3));
        for (int k = 0; k < 2; k++) if (pend[k]) drive_req(k, rand_fs(), $urandom(), $urandom(), 1'($urandom_range(0, 1)));
      end
      w = rr_pick(pend[0], pend[1], m_last);
      e = alu_calc(rfs[w], ra[w], rb[w], rc[w]);
      #1;
      n_checks++; if ({rdy1[0], rdy0[0]} !== ((w == 0) ? 2'b01 : 2'b10)) $display("FAIL rand_grant[%0d]: got %0b want winner %0d", r, {rdy1[0], rdy0[0]}, w); else n_pass++;
      tick();
      rv[w] = 1'b0; pend[w] = 1'b0; m_last = w[0];
      hold = $urandom_range(0, 3);
      wait_rsp(hold, rcyc, id, res, flg, ok);
      n_checks++; if (ok !== 1'b1 || id !== w[0] || {flg, res} !== e) $display("FAIL rand_rsp[%0d]: got ok %0d id %0d val %0h want 1 %0d %0h", r, ok, id, {flg, res}, w, e); else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; rv = 2'b00; rfs = '0; ra = '0; rb = '0; rc = 2'b00; rsp_ready = 1'b0;
    m_last = 1'b1;
    test_reset();
    test_single_add();
    test_both_valid();
    test_backpressure();
    test_reset_mid_issue();
    test_settle_sweep();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single registered ALU between two requesters (e.g. instruction sequencer and address-generation unit).
- Arbitrates round-robin, drives FunSel, operands and carry-in onto the ALU, and holds them stable until result and flags have settled.
- Captures result and flags and returns them on a shared response channel tagged with the requester id.
- Sits between the control unit and the ALU instance; the ALU is otherwise unmodified.

Parameters:
SETTLE, 3, clock edges after alu_* outputs become stable until alu_flags is valid (the ALU pipelines flags through internal registers); legal range 1..15
DATA_W, 32, operand/result width; fixed to 32 for the current ALU

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_funsel  input  5  ALU function code
req0_a  input  32  operand A
req0_b  input  32  operand B
req0_cin  input  1  carry-in
req1_valid / req1_ready / req1_funsel / req1_a / req1_b / req1_cin  same widths and meaning for requester 1
alu_funsel  output  5  to ALU FunSel
alu_a  output  32  to ALU input_a
alu_b  output  32  to ALU input_b
alu_cin  output  1  to ALU cin
alu_out  input  32  from ALU ALUOut
alu_flags  input  4  from ALU flags, Z|C|N|V (bits 3..0)
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_id  output  1  requester that issued the op
rsp_result  output  32  captured ALUOut
rsp_flags  output  4  captured flags Z|C|N|V

Behaviour:
- Reset is synchronous on the rising clock edge while reset=0.
  - All outputs go to 0 and state goes to IDLE.
  - The settle counter clears; last_grant is set to 1, so requester 0 wins first.
- Reset takes effect in any state, including mid-ISSUE or while rsp_valid=1. An in-flight op is discarded with no response.
- FSM: IDLE -> ISSUE -> DONE -> IDLE. Only one operation is outstanding at a time.
- IDLE:
  - Grant is combinational. If only one reqN_valid=1, grant that requester. If both are valid, grant the one not equal to last_grant.
  - reqN_ready=1 only in IDLE and only for the granted requester. The handshake is valid&ready in the same cycle (call it cycle 0).
  - On the handshake edge: register funsel/a/b/cin into alu_*, set rsp_id and last_grant to the granted id, clear the counter, and go to ISSUE.
- ISSUE:
  - alu_* are held constant.
  - The counter increments each cycle. Leave ISSUE at the edge ending cycle SETTLE+1.
  - On that edge: capture rsp_result<=alu_out and rsp_flags<=alu_flags, set rsp_valid=1, go to DONE.
  - With SETTLE=3, rsp_valid is first high in cycle 5 after acceptance.
- DONE:
  - rsp_* are held stable while rsp_ready=0.
  - On rsp_valid&rsp_ready: clear rsp_valid and go to IDLE. The next grant can occur in the following cycle at the earliest (no same-cycle accept).
- Outside ISSUE, alu_* keep their last values (no toggling). reqN_ready=0 in ISSUE and DONE.
- Requests must hold valid and fields stable until ready; the arbiter does not latch a request before the handshake.
- No arithmetic is performed in this block. Result and flags are passed through bit-exact.
- The counter is 4 bits wide and never wraps, since it exits at SETTLE+1 ≤ 16.

Decomposition:
- Shared package alu_pkg holds:
  - FunSel code constants (e.g. FS_ADD32=5'b10100, FS_SUB32=5'b10110, FS_XOR32=5'b11001).
  - Flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0.
  - Arbiter state encoding (IDLE/ISSUE/DONE).
- One sub-module is natural: rr_arb2, a 2-way round-robin grant from {valid0, valid1, last_grant}, purely combinational.

Test Plan:
- Reset, then req0 ADD32 (funsel 10100, a=5, b=7, cin=0), rsp_ready=1 -> req0_ready=1 in cycle 0; alu_funsel=10100 from cycle 1; rsp_valid=1 in cycle 5 with rsp_id=0, rsp_result=12, rsp_flags=4'b0000.
- req0 and req1 both valid in the same cycle after reset (req0 XOR32 0x10^0x10, req1 ADD32 1+1) -> req0 served first (rsp_result=0, rsp_flags[3]=1); req1 is granted in the first IDLE cycle after that response (rsp_id=1, rsp_result=2). Then with both requesters valid again, req0 wins.
- req1 SUB32 a=5, b=7, with rsp_ready=0 for 10 cycles -> rsp_result=0xFFFFFFFE and rsp_flags[1]=1, held stable all 10 cycles; req0_ready and req1_ready stay 0 throughout; the transfer completes on the cycle rsp_ready rises.
- reset=0 for one cycle during ISSUE (cycle 2) -> next cycle state=IDLE, rsp_valid=0, alu_*=0, no response emitted; a following req1 request is granted normally.
- Sweep SETTLE=1 and SETTLE=5 with ADD32 3+4 -> rsp_valid first high in cycle 3 and cycle 7 respectively; result 7 in both cases.
- Back-to-back req0 only, 4 ops with rsp_ready tied 1 -> each op's accept occurs in the cycle after the previous response handshake, with no lost or duplicated responses.
